// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the RISC-V core.
// Holds the program counter and fetches one 32-bit instruction at a time over
// a req/ready handshake. It presents the instruction and its opcode/funct
// fields to the control unit, and picks the next PC from the branch decision.
// A misaligned branch target parks the unit in HALT until reset.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        BranchEqual,
    input  logic [31:0] BranchOffset,
    input  logic        Stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] Instr,
    output logic [6:0]  OPCode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] PC,
    output logic        InstrValid,
    output logic        Halted,
    output logic [31:0] InstrCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic [31:0] next_pc;

    // Candidate next PC; it only takes effect on the consume edge, so
    // BranchEqual/BranchOffset are don't-cares at any other time.
    always_comb begin
        next_pc = BranchEqual ? (pc_q + BranchOffset) : (pc_q + 32'd4);
    end

    // Next-state logic for the fetch FSM and its datapath registers
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                // Address and request stay put until memory completes.
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Consume: count it, then either follow the target or halt
                // with PC left pointing at the offending branch.
                if (!Stall) begin
                    cnt_d = cnt_q + 32'd1;
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Request is registered: it is high exactly while in FETCH.
        req_d = (state_d == FETCH);
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            cnt_q   <= 32'd0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // Outputs: decode fields are plain slices of the captured word
    always_comb begin
        imem_req   = req_q;
        imem_addr  = pc_q;
        PC         = pc_q;
        Instr      = instr_q;
        OPCode     = instr_q[6:0];
        funct3     = instr_q[14:12];
        funct7     = instr_q[31:25];
        InstrValid = (state_q == ISSUE);
        Halted     = (state_q == HALT);
        InstrCount = cnt_q;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a small instruction ROM answers fetches,
// the stimulus process pushes the expected {PC, Instr} for every fetch it
// starts, and a monitor pops and compares whenever a new instruction issues.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        BranchEqual = 1'b0;
    logic [31:0] BranchOffset = 32'd0;
    logic        Stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b1;
    logic [31:0] Instr;
    logic [6:0]  OPCode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] PC;
    logic        InstrValid;
    logic        Halted;
    logic [31:0] InstrCount;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .BranchEqual(BranchEqual), .BranchOffset(BranchOffset), .Stall(Stall),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .Instr(Instr), .OPCode(OPCode), .funct3(funct3), .funct7(funct7),
        .PC(PC), .InstrValid(InstrValid), .Halted(Halted), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    // Instruction ROM contents
    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem = 32'h0000_0013;
            32'h0000_0004: mem = 32'h0050_0093;
            32'h0000_0008: mem = 32'h4020_8133;
            32'h0000_000C: mem = 32'h0020_9463;
            32'h0000_0010: mem = 32'hFE00_0CE3;
            32'h0000_0014: mem = 32'h0041_A023;
            32'h0000_0020: mem = 32'h0000_8067;
            default:       mem = 32'hDEAD_BEEF;
        endcase
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Current cycle must be FETCH at addr; queue the word it will deliver.
    task automatic expect_fetch(input logic [31:0] addr, input bit push);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, addr);
        chk("fetch_valid", {31'd0, InstrValid}, 32'd0);
        if (push) sb_q.push_back({addr, mem(addr)});
    endtask

    task automatic expect_issue(input logic [31:0] pc);
        chk("issue_valid", {31'd0, InstrValid}, 32'd1);
        chk("issue_req", {31'd0, imem_req}, 32'd0);
        chk("issue_pc", PC, pc);
    endtask

    // Monitor: compare each newly issued instruction against the scoreboard
    initial begin
        logic prev_v;
        logic [63:0] e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (InstrValid && !prev_v) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("mon_pc", PC, e[63:32]);
                    chk("mon_instr", Instr, e[31:0]);
                    chk("mon_opcode", {25'd0, OPCode}, {25'd0, e[6:0]});
                    chk("mon_funct3", {29'd0, funct3}, {29'd0, e[14:12]});
                    chk("mon_funct7", {25'd0, funct7}, {25'd0, e[31:25]});
                end
            end
            prev_v = InstrValid;
        end
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_opcode", {25'd0, OPCode}, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, InstrValid}, 32'd0);
        chk("rst_halted", {31'd0, Halted}, 32'd0);
        chk("rst_count", InstrCount, 32'd0);

        // Sequential fetch: cycle 0 IDLE, 1 FETCH, 2 ISSUE ...
        @(posedge clk); #1 rst = 1'b0;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        tick(); expect_fetch(32'h0, 1'b1);
        tick(); expect_issue(32'h0);
        tick(); expect_fetch(32'h4, 1'b1);
        chk("count_1", InstrCount, 32'd1);
        tick(); expect_issue(32'h4);
        tick(); expect_fetch(32'h8, 1'b1);
        chk("count_2", InstrCount, 32'd2);

        // Memory wait: ready low for 3 cycles, address held for 4
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'h8);
            chk("wait_instr", Instr, 32'h0050_0093);
        end
        imem_ready = 1'b1;
        tick(); expect_issue(32'h8);
        tick(); expect_fetch(32'hC, 1'b1);
        chk("count_3", InstrCount, 32'd3);
        tick(); expect_issue(32'hC);
        tick(); expect_fetch(32'h10, 1'b1);
        tick(); expect_issue(32'h10);

        // Taken branch at 0x10 with offset -8
        BranchEqual = 1'b1; BranchOffset = 32'hFFFF_FFF8;
        tick(); expect_fetch(32'h8, 1'b1);
        BranchEqual = 1'b0; BranchOffset = 32'd0;
        tick(); expect_issue(32'h8);
        tick(); expect_fetch(32'hC, 1'b1);
        tick(); expect_issue(32'hC);
        tick(); expect_fetch(32'h10, 1'b1);
        tick(); expect_issue(32'h10);
        // Not taken at 0x10
        tick(); expect_fetch(32'h14, 1'b1);
        tick(); expect_issue(32'h14);
        chk("count_8", InstrCount, 32'd8);

        // Stall for 2 cycles while BranchEqual toggles
        Stall = 1'b1; BranchEqual = 1'b1; BranchOffset = 32'h100;
        tick();
        expect_issue(32'h14);
        chk("stall_instr", Instr, 32'h0041_A023);
        chk("stall_count", InstrCount, 32'd8);
        BranchEqual = 1'b0;
        tick();
        expect_issue(32'h14);
        chk("stall_count2", InstrCount, 32'd8);
        Stall = 1'b0; BranchEqual = 1'b1; BranchOffset = 32'hC;
        tick(); expect_fetch(32'h20, 1'b1);
        chk("count_9", InstrCount, 32'd9);
        BranchEqual = 1'b0; BranchOffset = 32'd0;
        tick(); expect_issue(32'h20);

        // Misaligned target: 0x20 + 6
        BranchEqual = 1'b1; BranchOffset = 32'd6;
        tick();
        BranchEqual = 1'b0; BranchOffset = 32'd0;
        chk("halt_count", InstrCount, 32'd10);
        chk("halt_valid", {31'd0, InstrValid}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("halt_flag", {31'd0, Halted}, 32'd1);
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_pc", PC, 32'h20);
            tick();
        end

        // Reset out of HALT, then wrap through 0xFFFF_FFFC
        rst = 1'b1;
        #1;
        chk("rst2_pc", PC, 32'h0);
        chk("rst2_halted", {31'd0, Halted}, 32'd0);
        chk("rst2_count", InstrCount, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        tick(); expect_fetch(32'h0, 1'b1);
        tick(); expect_issue(32'h0);
        BranchEqual = 1'b1; BranchOffset = 32'hFFFF_FFFC;
        tick(); expect_fetch(32'hFFFF_FFFC, 1'b1);
        BranchEqual = 1'b0; BranchOffset = 32'd0;
        tick(); expect_issue(32'hFFFF_FFFC);
        tick(); expect_fetch(32'h0, 1'b1);
        tick(); expect_issue(32'h0);
        tick(); expect_fetch(32'h4, 1'b0);
        chk("wrap_count", InstrCount, 32'd3);

        // Reset mid-fetch: request drops at once, PC back to RESET_PC
        #2 rst = 1'b1;
        #1;
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_pc", PC, 32'h0);
        chk("midrst_count", InstrCount, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst_idle_req", {31'd0, imem_req}, 32'd0);
        tick(); expect_fetch(32'h0, 1'b1);
        tick(); expect_issue(32'h0);
        Stall = 1'b1;
        repeat (2) tick();

        chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
